// File: rtl/msi_snoop_bus.sv
// msi_snoop_bus: arbiter and sequencer for a shared snooping bus between
// MSI caches and one memory port. One transaction runs at a time: grant,
// optional snoop broadcast, optional dirty flush or memory access, then a
// one-cycle done pulse back to the owner.
module msi_snoop_bus #(
  parameter int NUM_PROC = 2,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 4,
  parameter int SRC_W    = ($clog2(NUM_PROC) > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PROC-1:0]        req,
  input  logic [2*NUM_PROC-1:0]      req_op,
  input  logic [ADDR_W*NUM_PROC-1:0] req_addr,
  input  logic [DATA_W*NUM_PROC-1:0] req_wdata,
  output logic [NUM_PROC-1:0]        gnt,
  output logic [NUM_PROC-1:0]        done,
  output logic [DATA_W-1:0]          rdata,
  output logic                       snoop_valid,
  output logic [1:0]                 snoop_op,
  output logic [ADDR_W-1:0]          snoop_addr,
  output logic [SRC_W-1:0]           snoop_src,
  input  logic [NUM_PROC-1:0]        snoop_hit_m,
  input  logic [DATA_W*NUM_PROC-1:0] snoop_data,
  output logic                       mem_rd,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic                       busy,
  output logic                       err
);

  localparam logic [1:0] OP_WB  = 2'd0;
  localparam logic [1:0] OP_INV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_FLUSH,
    ST_MEM,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Transaction context captured at grant time and held until done.
  logic [NUM_PROC-1:0] gnt_q, gnt_d;
  logic [SRC_W-1:0]    owner_q, owner_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   flush_q, flush_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [SRC_W-1:0]    last_q, last_d;
  logic                err_q, err_d;

  // Arbitration results.
  logic                pick_found;
  logic [NUM_PROC-1:0] pick_vec;
  logic [SRC_W-1:0]    pick_idx;
  logic [1:0]          pick_op;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  // Snoop response decode.
  logic [NUM_PROC-1:0] other_hits;
  logic                hit_found;
  logic                hit_multi;
  logic [DATA_W-1:0]   hit_data;

  // Round-robin pick: first requester above last_grant, else wrap to the lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_vec   = '0;
    pick_idx   = '0;
    pick_op    = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (!pick_found && req[i] && (i > int'(last_q))) begin
        pick_found  = 1'b1;
        pick_vec[i] = 1'b1;
        pick_idx    = SRC_W'(i);
        pick_op     = req_op[2*i +: 2];
        pick_addr   = req_addr[ADDR_W*i +: ADDR_W];
        pick_wdata  = req_wdata[DATA_W*i +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_PROC; i++) begin
      if (!pick_found && req[i]) begin
        pick_found  = 1'b1;
        pick_vec[i] = 1'b1;
        pick_idx    = SRC_W'(i);
        pick_op     = req_op[2*i +: 2];
        pick_addr   = req_addr[ADDR_W*i +: ADDR_W];
        pick_wdata  = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Snoop replies from everyone but the owner; lowest index supplies the data.
  always_comb begin
    other_hits = snoop_hit_m & ~gnt_q;
    hit_multi  = |(other_hits & (other_hits - NUM_PROC'(1)));
    hit_found  = 1'b0;
    hit_data   = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (!hit_found && other_hits[i]) begin
        hit_found = 1'b1;
        hit_data  = snoop_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next-state and next-context logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    flush_d = flush_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_vec;
          owner_d = pick_idx;
          op_d    = pick_op;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          rdata_d = '0;
          state_d = (pick_op == OP_WB) ? ST_MEM : ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (hit_multi) begin
          err_d = 1'b1;
        end
        if (op_q == OP_INV) begin
          state_d = ST_DONE;
        end else if (hit_found) begin
          flush_d = hit_data;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_FLUSH: begin
        if (mem_ready) begin
          rdata_d = flush_q;
          state_d = ST_DONE;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (op_q != OP_WB) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction context registers; last grant resets to the top index so proc 0 wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q   <= '0;
      owner_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      flush_q <= '0;
      rdata_q <= '0;
      last_q  <= SRC_W'(NUM_PROC - 1);
      err_q   <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      flush_q <= flush_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from the registered state and context only.
  assign gnt         = gnt_q;
  assign done        = (state_q == ST_DONE) ? gnt_q : '0;
  assign rdata       = rdata_q;
  assign snoop_valid = (state_q == ST_SNOOP);
  assign snoop_op    = snoop_valid ? op_q : 2'd0;
  assign snoop_addr  = snoop_valid ? addr_q : '0;
  assign snoop_src   = snoop_valid ? owner_q : '0;
  assign mem_rd      = (state_q == ST_MEM) && (op_q != OP_WB);
  assign mem_wr      = (state_q == ST_FLUSH) || ((state_q == ST_MEM) && (op_q == OP_WB));
  assign mem_addr    = (mem_rd || mem_wr) ? addr_q : '0;
  assign mem_wdata   = (state_q == ST_FLUSH) ? flush_q : (mem_wr ? wdata_q : '0);
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;

endmodule
